// File: rtl/store_buffer.sv
// Circular store buffer: queues core stores, drains them to data memory when the port is idle,
// and forwards the youngest matching buffered store to loads.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     st_valid_i,
  output logic                     st_ready_o,
  input  logic [31:0]              st_addr_i,
  input  logic [31:0]              st_data_i,
  input  logic                     ld_req_i,
  input  logic [31:0]              ld_addr_i,
  output logic                     ld_hit_o,
  output logic [31:0]              ld_data_o,
  input  logic                     mem_busy_i,
  output logic                     mem_write_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign count_o     = count_q;
  assign st_ready_o  = !full_o;
  assign push        = st_valid_i && !full_o;
  assign pop         = !empty_o && !mem_busy_i;
  assign mem_write_o = pop;
  assign mem_addr_o  = empty_o ? 32'h0 : addr_mem[rd_ptr_q];
  assign mem_wdata_o = empty_o ? 32'h0 : data_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Entry storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= st_addr_i;
      data_mem[wr_ptr_q] <= st_data_i;
    end
  end

  // Walk from oldest to youngest so the last match wins; only occupied slots are eligible.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = 32'h0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ld_req_i && (CW'(k) < count_q) && (addr_mem[rd_ptr_q + AW'(k)] == ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_mem[rd_ptr_q + AW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer at DEPTH=4.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i, st_data_i;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic        mem_busy_i;
  logic        mem_write_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [2:0]  count_o;
  logic        empty_o, full_o;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .st_valid_i  (st_valid_i),
    .st_ready_o  (st_ready_o),
    .st_addr_i   (st_addr_i),
    .st_data_i   (st_data_i),
    .ld_req_i    (ld_req_i),
    .ld_addr_i   (ld_addr_i),
    .ld_hit_o    (ld_hit_o),
    .ld_data_o   (ld_data_o),
    .mem_busy_i  (mem_busy_i),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .count_o     (count_o),
    .empty_o     (empty_o),
    .full_o      (full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [31:0] a, input logic [31:0] d);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_data_i  = d;
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(st_ready_o), 32'd1);
    check({tag, "_empty"}, 32'(empty_o), 32'd1);
    check({tag, "_full"},  32'(full_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_mwr"},   32'(mem_write_o), 32'd0);
    check({tag, "_maddr"}, mem_addr_o, 32'h0);
    check({tag, "_mdata"}, mem_wdata_o, 32'h0);
    check({tag, "_hit"},   32'(ld_hit_o), 32'd0);
    check({tag, "_ldata"}, ld_data_o, 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i    = 1'b0;
    st_valid_i = 1'b0;
    st_addr_i  = 32'h0;
    st_data_i  = 32'h0;
    ld_req_i   = 1'b1;
    ld_addr_i  = 32'h0;
    mem_busy_i = 1'b0;
    #12;
    check_reset_outputs("rst");
    ld_req_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();

    // Single store; not visible to memory before its push edge.
    st_valid_i = 1'b1;
    st_addr_i  = 32'h10;
    st_data_i  = 32'hAAAA_0001;
    #1;
    check("single_pre_mwr", 32'(mem_write_o), 32'd0);
    tick();
    st_valid_i = 1'b0;
    #1;
    check("single_mwr", 32'(mem_write_o), 32'd1);
    check("single_addr", mem_addr_o, 32'h10);
    check("single_data", mem_wdata_o, 32'hAAAA_0001);
    check("single_cnt", 32'(count_o), 32'd1);
    tick();
    check("single_empty", 32'(empty_o), 32'd1);
    check("single_mwr_off", 32'(mem_write_o), 32'd0);

    // Fill while memory busy, then drain in order.
    mem_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push_in(32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    check("fill_cnt", 32'(count_o), 32'd4);
    check("fill_full", 32'(full_o), 32'd1);
    check("fill_ready", 32'(st_ready_o), 32'd0);
    check("fill_mwr_busy", 32'(mem_write_o), 32'd0);
    push_in(32'h200, 32'hDEAD_BEEF);
    check("fill_drop_cnt", 32'(count_o), 32'd4);
    mem_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_mwr", 32'(mem_write_o), 32'd1);
      check("drain_addr", mem_addr_o, 32'h100 + 32'(4 * i));
      check("drain_data", mem_wdata_o, 32'hB000_0000 + 32'(i));
      tick();
    end
    check("drain_empty", 32'(empty_o), 32'd1);

    // Forwarding: youngest match wins, same-cycle store not forwarded.
    mem_busy_i = 1'b1;
    push_in(32'h20, 32'h11);
    push_in(32'h20, 32'h22);
    ld_req_i  = 1'b1;
    ld_addr_i = 32'h20;
    #1;
    check("fwd_hit", 32'(ld_hit_o), 32'd1);
    check("fwd_data", ld_data_o, 32'h22);
    ld_addr_i = 32'h24;
    #1;
    check("fwd_miss", 32'(ld_hit_o), 32'd0);
    check("fwd_miss_data", ld_data_o, 32'h0);
    st_valid_i = 1'b1;
    st_addr_i  = 32'h24;
    st_data_i  = 32'h33;
    #1;
    check("fwd_same_cycle", 32'(ld_hit_o), 32'd0);
    tick();
    st_valid_i = 1'b0;
    #1;
    check("fwd_after_push", 32'(ld_hit_o), 32'd1);
    check("fwd_after_data", ld_data_o, 32'h33);
    // Drain while loading 0x20: draining head still counts, popped entries do not.
    ld_addr_i  = 32'h20;
    mem_busy_i = 1'b0;
    #1;
    check("fwd_drain1_hit", ld_data_o, 32'h22);
    tick();
    check("fwd_drain2_mwr", 32'(mem_write_o), 32'd1);
    check("fwd_drain2_addr", mem_addr_o, 32'h20);
    check("fwd_drain2_data", ld_data_o, 32'h22);
    check("fwd_drain2_hit", 32'(ld_hit_o), 32'd1);
    tick();
    check("fwd_stale_hit", 32'(ld_hit_o), 32'd0);
    check("fwd_stale_data", ld_data_o, 32'h0);
    tick();
    check("fwd_empty", 32'(empty_o), 32'd1);
    ld_req_i = 1'b0;

    // Wrap-around: 10 stores, each drained the cycle after its push.
    for (int i = 0; i < 10; i++) begin
      st_valid_i = 1'b1;
      st_addr_i  = 32'h300 + 32'(4 * i);
      st_data_i  = 32'hC000_0000 + 32'(i);
      #1;
      if (i > 0) begin
        check("wrap_mwr", 32'(mem_write_o), 32'd1);
        check("wrap_addr", mem_addr_o, 32'h300 + 32'(4 * (i - 1)));
        check("wrap_data", mem_wdata_o, 32'hC000_0000 + 32'(i - 1));
        check("wrap_cnt", 32'(count_o), 32'd1);
      end
      tick();
    end
    st_valid_i = 1'b0;
    #1;
    check("wrap_last_addr", mem_addr_o, 32'h324);
    check("wrap_last_data", mem_wdata_o, 32'hC000_0009);
    tick();
    ld_req_i  = 1'b1;
    ld_addr_i = 32'h324;
    #1;
    check("wrap_stale_hit", 32'(ld_hit_o), 32'd0);
    ld_addr_i = 32'h300;
    #1;
    check("wrap_stale_hit0", 32'(ld_hit_o), 32'd0);
    ld_req_i = 1'b0;

    // Simultaneous push and pop; full with drain keeps ready low.
    mem_busy_i = 1'b1;
    push_in(32'h404, 32'hD01);
    push_in(32'h408, 32'hD02);
    check("sim_cnt2", 32'(count_o), 32'd2);
    mem_busy_i = 1'b0;
    st_valid_i = 1'b1;
    st_addr_i  = 32'h40C;
    st_data_i  = 32'hD03;
    #1;
    check("sim_mwr", 32'(mem_write_o), 32'd1);
    tick();
    st_valid_i = 1'b0;
    mem_busy_i = 1'b1;
    check("sim_cnt_hold", 32'(count_o), 32'd2);
    push_in(32'h410, 32'hD04);
    push_in(32'h414, 32'hD05);
    check("sim_full", 32'(full_o), 32'd1);
    mem_busy_i = 1'b0;
    st_valid_i = 1'b1;
    st_addr_i  = 32'h500;
    st_data_i  = 32'hD99;
    #1;
    check("sim_full_ready", 32'(st_ready_o), 32'd0);
    check("sim_full_mwr", 32'(mem_write_o), 32'd1);
    tick();
    st_valid_i = 1'b0;
    check("sim_cnt3", 32'(count_o), 32'd3);
    for (int i = 3; i < 6; i++) begin
      #1;
      check("sim_drain_addr", mem_addr_o, 32'h400 + 32'(4 * i));
      check("sim_drain_data", mem_wdata_o, 32'hD00 + 32'(i));
      tick();
    end
    check("sim_empty", 32'(empty_o), 32'd1);

    // Reset mid-operation discards pending stores.
    mem_busy_i = 1'b1;
    push_in(32'h600, 32'hE01);
    push_in(32'h604, 32'hE02);
    push_in(32'h608, 32'hE03);
    check("mid_cnt3", 32'(count_o), 32'd3);
    #2;
    reset_i   = 1'b0;
    ld_req_i  = 1'b1;
    ld_addr_i = 32'h604;
    #1;
    check_reset_outputs("mid");
    mem_busy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mid_hold_mwr", 32'(mem_write_o), 32'd0);
    end
    reset_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mid_post_mwr", 32'(mem_write_o), 32'd0);
      check("mid_post_hit", 32'(ld_hit_o), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
